// File: rtl/riscv_test_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_test_pkg : verdict encoding and hang-detector constants        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package riscv_test_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_TIMEOUT = 3'd3,
    ST_HANG    = 3'd4
  } status_e;

  localparam int HANG_LIMIT = 256;
  // One extra bit so the stall count can hold HANG_LIMIT itself.
  localparam int STALL_W = $clog2(HANG_LIMIT) + 1;

endpackage
`default_nettype wire

// File: rtl/riscv_test_monitor_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter : up-counter that sticks at all-ones, sync clear         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/riscv_test_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | riscv_test_monitor : watches tohost stores and reports a verdict;    |
// | TEST_MONITOR_HANG_EN adds a retire-stall hang detector.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module riscv_test_monitor
  import riscv_test_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h0000_1000,
  parameter int                TIMEOUT     = 5000,
  parameter int                CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              retire,
  output logic              done,
  output logic              pass,
  output logic [2:0]        status,
  output logic [DATA_W-2:0] fail_test,
  output logic [CNT_W-1:0]  cycles,
  output logic [CNT_W-1:0]  instret
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  status_e           state;
  status_e           state_nxt;
  logic [DATA_W-2:0] fail_q;
  logic              hit;
  logic              hit_pass;
  logic              hit_fail;
  logic              timeout_hit;
  logic              hang_hit;
  logic              stay_run;

  // Even nonzero tohost values are syscalls and fall through untouched.
  assign hit         = st_valid && (st_addr == TOHOST_ADDR) && (st_data != '0);
  assign hit_pass    = hit && (st_data == DATA_W'(1));
  assign hit_fail    = hit && st_data[0] && !hit_pass;
  assign timeout_hit = (TIMEOUT != 0) && (cycles == TIMEOUT_LAST);

`ifdef TEST_MONITOR_HANG_EN
  logic [STALL_W-1:0] stall_cnt;

  sat_counter #(.W(STALL_W)) u_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   ((state == ST_RUN) && !retire),
    .clr   (retire),
    .count (stall_cnt)
  );

  assign hang_hit = !retire && (stall_cnt == STALL_W'(HANG_LIMIT - 1));
`else
  assign hang_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_RUN) begin
      if (hit_pass) begin
        state_nxt = ST_PASS;
      end else if (hit_fail) begin
        state_nxt = ST_FAIL;
      end else if (timeout_hit) begin
        state_nxt = ST_TIMEOUT;
      end else if (hang_hit) begin
        state_nxt = ST_HANG;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_q <= '0;
    end else if ((state == ST_RUN) && hit_fail) begin
      fail_q <= st_data[DATA_W-1:1];
    end
  end

  // Counters stop on the verdict edge itself, so they report the last RUN cycle.
  assign stay_run = (state == ST_RUN) && (state_nxt == ST_RUN);

  sat_counter #(.W(CNT_W)) u_cycles (
    .clk   (clk),
    .rst   (rst),
    .inc   (stay_run),
    .clr   (1'b0),
    .count (cycles)
  );

  sat_counter #(.W(CNT_W)) u_instret (
    .clk   (clk),
    .rst   (rst),
    .inc   (stay_run && retire),
    .clr   (1'b0),
    .count (instret)
  );

  assign done      = (state != ST_RUN);
  assign pass      = (state == ST_PASS);
  assign status    = state;
  assign fail_test = fail_q;

endmodule
`default_nettype wire

// File: doc/riscv_test_monitor.md
RISCV_TEST_MONITOR -- requirements
Module: riscv_test_monitor

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, store-bus address width.
REQ-002 SHALL have parameter DATA_W, default 32, store-bus data width (32 or 64).
REQ-003 SHALL have parameter TOHOST_ADDR, default 32'h0000_1000, tohost word address.
REQ-004 SHALL have parameter TIMEOUT, default 5000, cycle budget; 0 disables the timeout.
REQ-005 SHALL have parameter CNT_W, default 32, cycle and instret counter width.
REQ-006 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port st_valid, input, 1, a core store is committing this cycle.
REQ-009 SHALL have port st_addr, input, ADDR_W, store address.
REQ-010 SHALL have port st_data, input, DATA_W, store data.
REQ-011 SHALL have port retire, input, 1, one instruction retired this cycle.
REQ-012 SHALL have port done, output, 1, a verdict has been reached (sticky).
REQ-013 SHALL have port pass, output, 1, the verdict is pass.
REQ-014 SHALL have port status, output, 3, encoded verdict: RUN, PASS, FAIL, TIMEOUT, HANG.
REQ-015 SHALL have port fail_test, output, DATA_W-1, failing test number (tohost>>1).
REQ-016 SHALL have port cycles, output, CNT_W, cycles spent in RUN.
REQ-017 SHALL have port instret, output, CNT_W, instructions retired in RUN.

Function
REQ-018 FSM states SHALL be RUN, PASS, FAIL, TIMEOUT, HANG; all except RUN are terminal.
REQ-019 A tohost hit SHALL be st_valid=1 with st_addr==TOHOST_ADDR and st_data!=0.
REQ-020 In RUN, a hit with st_data==1 SHALL move to PASS on the next edge.
REQ-021 In RUN, a hit with odd st_data!=1 SHALL move to FAIL and latch fail_test=st_data>>1.
REQ-022 In RUN, a hit with even nonzero st_data (syscall) SHALL be ignored.
REQ-023 In RUN, cycles SHALL increment every cycle, and instret SHALL increment when retire=1.
REQ-024 Counters SHALL saturate at all-ones, never wrap, and freeze in terminal states.
REQ-025 With TIMEOUT!=0, the first edge at which cycles==TIMEOUT-1 with no hit SHALL move to TIMEOUT.
REQ-026 A tohost hit and timeout expiry on the same edge SHALL resolve as the hit (PASS/FAIL wins).
REQ-027 done SHALL assert on the first cycle after the terminal transition; pass=1 only in PASS.
REQ-028 Once terminal, further stores and retires SHALL NOT change any output.
REQ-029 Verdict latency SHALL be exactly one cycle from the hit cycle.

Reset
REQ-030 Asserting rst=0 at any time, including mid-run or after a verdict, SHALL immediately force state RUN with done=0, pass=0, fail_test=0, cycles=0 and instret=0.
REQ-031 Release of rst SHALL take effect on a clk edge; counting SHALL begin on the first edge after release.

Configuration
REQ-032 Macro TEST_MONITOR_HANG_EN SHALL compile in a hang detector.
REQ-033 With TEST_MONITOR_HANG_EN defined, 256 consecutive RUN cycles with retire=0 SHALL move to HANG; a tohost hit on the same edge SHALL win.
REQ-034 Without TEST_MONITOR_HANG_EN, no stall counter SHALL exist and HANG SHALL be unreachable.

Structure
REQ-035 The status encoding enum and the HANG_LIMIT=256 constant SHALL live in shared package riscv_test_pkg.
REQ-036 Saturating counters SHALL be one sub-module sat_counter (parameter W, inputs inc and clr), instanced for cycles, instret and the stall counter.

Verification
REQ-037 Bench SHALL drive store TOHOST_ADDR/data 1 at cycle 40 -> done=1 and pass=1 at cycle 41, status=PASS, cycles=40.
REQ-038 Bench SHALL drive store data 7 -> status=FAIL, fail_test=3, pass=0.
REQ-039 Bench SHALL run TIMEOUT=100 with no hit -> status=TIMEOUT at cycle 100, cycles frozen at 99.
REQ-040 Bench SHALL apply a hit with data 1 on the expiry edge at TIMEOUT=100 -> status=PASS.
REQ-041 Bench SHALL store data 2, then data 1 -> first store ignored, final status=PASS.
REQ-042 With TEST_MONITOR_HANG_EN, bench SHALL hold retire=0 for 256 cycles -> status=HANG; pulsing rst=0 afterwards -> all outputs return to 0 asynchronously.
